// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus. Stage stall requests and exception info go in;
// hold, flush and redirect controls plus statistics come out.
interface pipe_ctrl_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        bus_timeout;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   // Pipeline side: raises requests and consumes the controls
   modport master (
      output stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
      input  stall, flush, new_pc, bus_timeout, stall_cycles, flush_count
   );

   // Controller side
   modport slave (
      input  stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
      output stall, flush, new_pc, bus_timeout, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with MEM-stage bus timeout watchdog.
// Controls are combinational from inputs and state; only the wait FSM and
// the statistics counters are registered.
module pipe_ctrl #(
   parameter logic [31:0] EXC_BASE    = 32'h00000020,
   parameter logic [7:0]  STALL_LIMIT = 8'd255
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, MEMWAIT, TMO} state_t;

   state_t      state, state_nxt;
   logic [7:0]  stall_cnt, stall_cnt_nxt;
   logic        exc, timeout;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        bus_timeout;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   assign exc     = (bus.excepttype != 32'h0);
   // The counter only reaches STALL_LIMIT while waiting, so the MEMWAIT
   // qualifier just documents where a timeout can happen.
   assign timeout = (state == MEMWAIT) && bus.stallreq_mem && (stall_cnt == STALL_LIMIT);

   // Priority resolution of controls and next-state; reset and exceptions
   // both fall through to RUN with a cleared wait counter.
   always_comb begin
      state_nxt     = RUN;
      stall_cnt_nxt = 8'd0;
      stall         = 6'b000000;
      flush         = 1'b0;
      new_pc        = 32'h0;
      bus_timeout   = 1'b0;
      if (rst) begin
         // everything quiet this cycle
      end else if (exc) begin
         flush  = 1'b1;
         new_pc = (bus.excepttype == 32'h0000000e) ? bus.cp0_epc : EXC_BASE;
      end else if (timeout) begin
         flush       = 1'b1;
         new_pc      = EXC_BASE;
         bus_timeout = 1'b1;
         state_nxt   = TMO;
      end else begin
         if (bus.stallreq_mem)     stall = 6'b011111;
         else if (bus.stallreq_ex) stall = 6'b001111;
         else if (bus.stallreq_id) stall = 6'b000111;
         if (bus.stallreq_mem) begin
            state_nxt = MEMWAIT;
            // below STALL_LIMIT here, so the increment cannot wrap
            stall_cnt_nxt = (state == MEMWAIT) ? stall_cnt + 8'd1 : 8'd1;
         end
      end
   end

   // Wait FSM state and consecutive-stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         stall_cnt <= 8'd0;
      end else begin
         state     <= state_nxt;
         stall_cnt <= stall_cnt_nxt;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'h0;
         flush_count  <= 16'h0;
      end else begin
         if (stall != 6'b0 && stall_cycles != 32'hFFFFFFFF) stall_cycles <= stall_cycles + 32'd1;
         if (flush && flush_count != 16'hFFFF)               flush_count  <= flush_count + 16'd1;
      end
   end

   assign bus.stall        = stall;
   assign bus.flush        = flush;
   assign bus.new_pc       = new_pc;
   assign bus.bus_timeout  = bus_timeout;
   assign bus.stall_cycles = stall_cycles;
   assign bus.flush_count  = flush_count;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a reference model predicts each cycle's controls and
// counters, pushes them to a scoreboard, and the sampled DUT outputs are
// popped against them on the falling edge.
module tb_pipe_ctrl;
   localparam int LIMIT = 4;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        bt;
      logic [31:0] sc;
      logic [15:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   pipe_ctrl_if bus();

   pipe_ctrl #(.EXC_BASE(32'h00000020), .STALL_LIMIT(8'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          m_run  = 0;      // consecutive accepted MEM-stall cycles
   logic [31:0] m_sc   = 32'h0;
   logic [15:0] m_fc   = 16'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict, sample at negedge, advance the model
   task automatic step(input string tag, input logic r, input logic mem, input logic ex,
                       input logic id, input logic [31:0] exc, input logic [31:0] epc);
      exp_t e;
      exp_t g;
      @(posedge clk);
      #1;
      rst = r;
      bus.stallreq_mem = mem;
      bus.stallreq_ex  = ex;
      bus.stallreq_id  = id;
      bus.excepttype   = exc;
      bus.cp0_epc      = epc;
      e.stall = 6'h0; e.flush = 1'b0; e.new_pc = 32'h0; e.bt = 1'b0;
      e.sc = m_sc; e.fc = m_fc;
      if (r) begin
         m_run = 0;
      end else if (exc != 0) begin
         e.flush  = 1'b1;
         e.new_pc = (exc == 32'he) ? epc : 32'h20;
         m_run    = 0;
      end else if (mem && m_run == LIMIT) begin
         e.flush = 1'b1; e.new_pc = 32'h20; e.bt = 1'b1;
         m_run   = 0;
      end else begin
         e.stall = mem ? 6'b011111 : ex ? 6'b001111 : id ? 6'b000111 : 6'b000000;
         m_run   = mem ? m_run + 1 : 0;
      end
      sb.push_back(e);
      @(negedge clk);
      chk({tag, ":sb"}, sb.size(), 1);
      if (sb.size() != 0) begin
         g = sb.pop_front();
         chk({tag, ":stall"},  bus.stall,        g.stall);
         chk({tag, ":flush"},  bus.flush,        g.flush);
         chk({tag, ":new_pc"}, bus.new_pc,       g.new_pc);
         chk({tag, ":tmo"},    bus.bus_timeout,  g.bt);
         chk({tag, ":scyc"},   bus.stall_cycles, g.sc);
         chk({tag, ":fcnt"},   bus.flush_count,  g.fc);
      end
      if (r) begin
         m_sc = 32'h0; m_fc = 16'h0;
      end else begin
         if (e.stall != 0 && m_sc != 32'hFFFFFFFF) m_sc++;
         if (e.flush && m_fc != 16'hFFFF) m_fc++;
      end
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic memc(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      bus.stallreq_mem = 1'b0; bus.stallreq_ex = 1'b0; bus.stallreq_id = 1'b0;
      bus.excepttype = 32'h0; bus.cp0_epc = 32'h0;
      repeat (2) @(posedge clk);
      // reset held with pending requests: outputs stay quiet
      step("rst", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
      step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);

      // EX and ID together for three cycles
      for (int i = 0; i < 3; i++) step("exid", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
      idle("exid_post");
      chk("exid_total", bus.stall_cycles, 32'd3);
      step("id", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

      // exception beats a MEM stall
      step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step("exc8", 1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
      idle("exc8_post");
      chk("exc8_fcnt", bus.flush_count, 16'd1);

      // eret redirects to EPC
      step("eret", 1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h00001234);
      chk("eret_pc", bus.new_pc, 32'h00001234);

      // timeout: 4 stall cycles, timeout on the 5th, fresh wait afterwards
      step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      memc("tmo_a", 4);
      step("tmo_hit", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      memc("tmo_b", 4);
      step("tmo_hit2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle("tmo_end");

      // a low cycle clears the wait counter
      memc("gap_a", 3);
      idle("gap");
      memc("gap_b", 4);
      idle("gap_end");

      // exception mid-wait suppresses the timeout
      memc("excw", 4);
      step("excw_hit", 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      memc("excw_b", 2);
      idle("excw_end");

      // reset mid-wait aborts without a timeout
      memc("rstw", 3);
      step("rstw_rst", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      memc("rstw_b", 4);
      step("rstw_hit", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle("rstw_end");

      // random traffic, MEM-heavy so timeouts occur
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ev;
         int          sel;
         sel = $urandom_range(0, 99);
         ev  = (sel < 3) ? 32'he : (sel < 6) ? $urandom() | 32'h1 : 32'h0;
         step("rnd", ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7),
              $urandom_range(0, 1), $urandom_range(0, 1), ev, $urandom());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
